lcd_8080_responder: RTL and testbench

LCD_8080_RESPONDER -- requirements
Module: lcd_8080_responder

---
 rtl/lcd_8080_pkg.sv | 37 +++
 rtl/lcd_bus_sync.sv | 44 ++++
 rtl/lcd_8080_responder.sv | 169 ++++++++++++++++
 tb/tb_lcd_8080_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_8080_pkg.sv
// Shared opcodes, FSM states, bus record and ID table for the 8080 LCD responder.
package lcd_8080_pkg;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_RDID    = 8'hD3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CASET = 3'd1,
      PASET = 3'd2,
      RAMWR = 3'd3,
      RDID  = 3'd4
   } state_t;

   typedef struct packed {
      logic        cs_n;
      logic        rs;
      logic        wr_n;
      logic        rd_n;
      logic        rst_n;
      logic [15:0] dat;
   } bus_t;

   localparam bus_t BUS_IDLE = '{cs_n: 1'b1, rs: 1'b0, wr_n: 1'b1, rd_n: 1'b1,
                                 rst_n: 1'b1, dat: 16'h0000};

   // Element [0] is the first word returned after the RDID opcode.
   localparam logic [3:0][15:0] ID_WORDS = {16'h0041, 16'h0093, 16'h0000, 16'h0000};

   function automatic logic [15:0] id_word(input logic [1:0] idx, input logic past_end);
      return past_end ? 16'h0000 : ID_WORDS[idx];
   endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the async 8080 strobes plus WR/RD edge detection.
// Latency: events fire 2 cycles after the pin change; no backpressure.
module lcd_bus_sync
   import lcd_8080_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  bus_t        bus_async,
   output logic        s_rs,
   output logic        s_rst_n,
   output logic [15:0] s_dat,
   output logic        wr_evt,
   output logic        rd_fall,
   output logic        rd_rise
);

   bus_t meta;
   bus_t bus;
   logic wr_q;
   logic rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= BUS_IDLE;
         bus  <= BUS_IDLE;
         wr_q <= 1'b1;
         rd_q <= 1'b1;
      end else begin
         meta <= bus_async;
         bus  <= meta;
         wr_q <= bus.wr_n;
         rd_q <= bus.rd_n;
      end
   end

   // RS and data come from the same stage as the WR sample that makes the edge.
   assign wr_evt  = bus.wr_n & ~wr_q & ~bus.cs_n;
   assign rd_fall = ~bus.rd_n & rd_q & ~bus.cs_n;
   assign rd_rise = bus.rd_n & ~rd_q;
   assign s_rs    = bus.rs;
   assign s_rst_n = bus.rst_n;
   assign s_dat   = bus.dat;

endmodule

// File: rtl/lcd_8080_responder.sv
// 8080-bus LCD controller model: decodes CASET/PASET/RAMWR/RDID and streams pixels.
// Latency: pixel 1 cycle after sync'd write; a pixel meeting a stalled output is dropped (pix_ovf).
module lcd_8080_responder
   import lcd_8080_pkg::*;
#(
   parameter int H_RES = 240,
   parameter int V_RES = 320
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        LCD_CS,
   input  logic        LCD_RS,
   input  logic        LCD_WR,
   input  logic        LCD_RD,
   input  logic        LCD_RST,
   input  logic [15:0] lcd_data_i,
   output logic [15:0] lcd_data_o,
   output logic        lcd_data_oe,
   output logic        pix_valid,
   output logic [8:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic [15:0] pix_data,
   input  logic        pix_ready,
   output logic        pix_ovf
);

   localparam logic [8:0] EC_DEF = 9'(H_RES - 1);
   localparam logic [8:0] EP_DEF = 9'(V_RES - 1);

   bus_t        bus_async;
   logic        s_rs;
   logic        s_rst_n;
   logic [15:0] s_dat;
   logic        wr_evt;
   logic        rd_fall;
   logic        rd_rise;

   state_t      state;
   logic [1:0]  idx;
   logic        id_done;
   logic [8:0]  sc, ec, sp, ep;
   logic [8:0]  cur_x, cur_y;
   logic        cmd_wr;
   logic        dat_wr;
   logic        soft_rst;

   assign bus_async = {LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, lcd_data_i};

   lcd_bus_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .bus_async (bus_async),
      .s_rs      (s_rs),
      .s_rst_n   (s_rst_n),
      .s_dat     (s_dat),
      .wr_evt    (wr_evt),
      .rd_fall   (rd_fall),
      .rd_rise   (rd_rise)
   );

   assign cmd_wr   = wr_evt & ~s_rs;
   assign dat_wr   = wr_evt & s_rs;
   assign soft_rst = ~s_rst_n | (cmd_wr & (s_dat[7:0] == CMD_SWRESET));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 2'd0;
         id_done     <= 1'b0;
         sc          <= 9'd0;
         ec          <= EC_DEF;
         sp          <= 9'd0;
         ep          <= EP_DEF;
         cur_x       <= 9'd0;
         cur_y       <= 9'd0;
         pix_valid   <= 1'b0;
         pix_x       <= 9'd0;
         pix_y       <= 9'd0;
         pix_data    <= 16'h0000;
         pix_ovf     <= 1'b0;
         lcd_data_o  <= 16'h0000;
         lcd_data_oe <= 1'b0;
      end else begin
         if (pix_valid && pix_ready)
            pix_valid <= 1'b0;

         if (rd_fall) begin
            lcd_data_oe <= 1'b1;
            lcd_data_o  <= (state == RDID) ? id_word(idx, id_done) : 16'h0000;
         end else if (rd_rise && lcd_data_oe) begin
            lcd_data_oe <= 1'b0;
            // idx parks at 3; id_done makes every later read return zero.
            if (state == RDID) begin
               if (idx == 2'd3)
                  id_done <= 1'b1;
               else
                  idx <= idx + 2'd1;
            end
         end

         if (soft_rst) begin
            sc        <= 9'd0;
            ec        <= EC_DEF;
            sp        <= 9'd0;
            ep        <= EP_DEF;
            state     <= IDLE;
            idx       <= 2'd0;
            id_done   <= 1'b0;
            pix_valid <= 1'b0;
         end else if (cmd_wr) begin
            idx     <= 2'd0;
            id_done <= 1'b0;
            case (s_dat[7:0])
               CMD_CASET: state <= CASET;
               CMD_PASET: state <= PASET;
               CMD_RAMWR: begin
                  state <= RAMWR;
                  cur_x <= sc;
                  cur_y <= sp;
               end
               CMD_RDID:  state <= RDID;
               default:   state <= IDLE;
            endcase
         end else if (dat_wr) begin
            case (state)
               CASET, PASET: begin
                  if (state == CASET) begin
                     case (idx)
                        2'd0: sc[8]   <= s_dat[0];
                        2'd1: sc[7:0] <= s_dat[7:0];
                        2'd2: ec[8]   <= s_dat[0];
                        default: ec[7:0] <= s_dat[7:0];
                     endcase
                  end else begin
                     case (idx)
                        2'd0: sp[8]   <= s_dat[0];
                        2'd1: sp[7:0] <= s_dat[7:0];
                        2'd2: ep[8]   <= s_dat[0];
                        default: ep[7:0] <= s_dat[7:0];
                     endcase
                  end
                  idx <= idx + 2'd1;
                  if (idx == 2'd3)
                     state <= IDLE;
               end
               RAMWR: begin
                  if (pix_valid && !pix_ready) begin
                     pix_ovf <= 1'b1;
                  end else begin
                     pix_valid <= 1'b1;
                     pix_x     <= cur_x;
                     pix_y     <= cur_y;
                     pix_data  <= s_dat;
                  end
                  // The cursor moves even when the pixel is dropped.
                  if (cur_x == ec) begin
                     cur_x <= sc;
                     cur_y <= (cur_y == ep) ? sp : cur_y + 9'd1;
                  end else begin
                     cur_x <= cur_x + 9'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_8080_responder.sv
// Bench for lcd_8080_responder: vector tables, directed corner sequences and random windows.
module tb_lcd_8080_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        LCD_CS = 1'b1, LCD_RS = 1'b0, LCD_WR = 1'b1, LCD_RD = 1'b1, LCD_RST = 1'b1;
   logic [15:0] lcd_data_i = 16'h0000;
   logic [15:0] lcd_data_o;
   logic        lcd_data_oe;
   logic        pix_valid;
   logic [8:0]  pix_x, pix_y;
   logic [15:0] pix_data;
   logic        pix_ready = 1'b1;
   logic        pix_ovf;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   typedef struct {
      logic        rs;
      logic [15:0] d;
      logic        chk;
      int          ex;
      int          ey;
   } vec_t;

   pix_t got_q[$];

   always #5 clk = ~clk;

   lcd_8080_responder #(.H_RES(240), .V_RES(320)) dut (
      .clk         (clk),
      .rst         (rst),
      .LCD_CS      (LCD_CS),
      .LCD_RS      (LCD_RS),
      .LCD_WR      (LCD_WR),
      .LCD_RD      (LCD_RD),
      .LCD_RST     (LCD_RST),
      .lcd_data_i  (lcd_data_i),
      .lcd_data_o  (lcd_data_o),
      .lcd_data_oe (lcd_data_oe),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_data    (pix_data),
      .pix_ready   (pix_ready),
      .pix_ovf     (pix_ovf)
   );

   // Every cycle showing valid&ready at the falling edge is one accepted pixel.
   always @(negedge clk)
      if (!rst && pix_valid && pix_ready)
         got_q.push_back({pix_x, pix_y, pix_data});

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic rs, input logic [15:0] d);
      LCD_CS = 1'b0; LCD_RS = rs; lcd_data_i = d; LCD_WR = 1'b0;
      tick(4);
      LCD_WR = 1'b1;
      tick(4);
      LCD_CS = 1'b1;
      tick(1);
   endtask

   task automatic bus_rd(output logic [15:0] d, output logic oe_lo, output logic oe_hi);
      LCD_CS = 1'b0; LCD_RD = 1'b0;
      tick(5);
      @(negedge clk);
      d = lcd_data_o; oe_lo = lcd_data_oe;
      tick(1);
      LCD_RD = 1'b1;
      tick(5);
      @(negedge clk);
      oe_hi = lcd_data_oe;
      tick(1);
      LCD_CS = 1'b1;
      tick(1);
   endtask

   task automatic set_window(input int sc, input int ec, input int sp, input int ep);
      logic [7:0] junk;
      junk = 8'($urandom);
      bus_wr(1'b0, 16'h002A);
      bus_wr(1'b1, {junk, 8'(sc >> 8)});
      bus_wr(1'b1, {junk, 8'(sc)});
      bus_wr(1'b1, {junk, 8'(ec >> 8)});
      bus_wr(1'b1, {junk, 8'(ec)});
      bus_wr(1'b0, 16'h002B);
      bus_wr(1'b1, {junk, 8'(sp >> 8)});
      bus_wr(1'b1, {junk, 8'(sp)});
      bus_wr(1'b1, {junk, 8'(ep >> 8)});
      bus_wr(1'b1, {junk, 8'(ep)});
   endtask

   // Pixel k of a RAMWR burst lands at row-major position k inside the window, wrapping.
   function automatic pix_t model_pix(input int sc, input int ec, input int sp, input int ep,
                                      input int k, input logic [15:0] d);
      int   w;
      int   h;
      pix_t p;
      w   = ec - sc + 1;
      h   = ep - sp + 1;
      p.x = 9'(sc + k % w);
      p.y = 9'(sp + (k / w) % h);
      p.d = d;
      return p;
   endfunction

   task automatic expect_pix(input string name, input pix_t e);
      int   n;
      pix_t p;
      n = 0;
      while (got_q.size() == 0 && n < 20) begin
         tick(1);
         n++;
      end
      if (got_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no pixel within 20 cycles, expected %h", name, e);
      end else begin
         p = got_q.pop_front();
         check(name, p, e);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      @(negedge clk);
      check({tag, "_pix_valid"}, 34'(pix_valid), 34'd0);
      check({tag, "_pix_x"}, 34'(pix_x), 34'd0);
      check({tag, "_pix_y"}, 34'(pix_y), 34'd0);
      check({tag, "_pix_data"}, 34'(pix_data), 34'd0);
      check({tag, "_pix_ovf"}, 34'(pix_ovf), 34'd0);
      check({tag, "_lcd_data_o"}, 34'(lcd_data_o), 34'd0);
      check({tag, "_lcd_data_oe"}, 34'(lcd_data_oe), 34'd0);
   endtask

   initial begin
      vec_t        vecs[$];
      logic [15:0] id_exp[5];
      logic [15:0] d;
      logic        oe_lo, oe_hi;
      int          sc, ec, sp, ep, n;

      id_exp = '{16'h0000, 16'h0000, 16'h0093, 16'h0041, 16'h0000};

      vecs.push_back('{1'b0, 16'h002A, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h5500, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0000, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'hAA00, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0002, 1'b0, 0, 0});
      vecs.push_back('{1'b0, 16'h002B, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0000, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0000, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0000, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'h0001, 1'b0, 0, 0});
      vecs.push_back('{1'b0, 16'h002C, 1'b0, 0, 0});
      vecs.push_back('{1'b1, 16'hA001, 1'b1, 0, 0});
      vecs.push_back('{1'b1, 16'hA002, 1'b1, 1, 0});
      vecs.push_back('{1'b1, 16'hA003, 1'b1, 2, 0});
      vecs.push_back('{1'b1, 16'hA004, 1'b1, 0, 1});
      vecs.push_back('{1'b1, 16'hA005, 1'b1, 1, 1});
      vecs.push_back('{1'b1, 16'hA006, 1'b1, 2, 1});
      vecs.push_back('{1'b1, 16'hA007, 1'b1, 0, 0});

      // Reset values
      tick(3);
      check_idle_outputs("reset");
      rst = 1'b0;
      tick(2);

      // Default window 240x320 after reset
      bus_wr(1'b0, 16'h002C);
      for (int k = 0; k < 241; k++) begin
         d = 16'($urandom);
         bus_wr(1'b1, d);
         expect_pix($sformatf("default_px%0d", k), model_pix(0, 239, 0, 319, k, d));
      end

      // Data in IDLE is ignored, then the 3x2 window vector table
      bus_wr(1'b0, 16'h0000);
      bus_wr(1'b1, 16'hDEAD);
      tick(3);
      check("idle_data_ignored", 34'(got_q.size()), 34'd0);
      foreach (vecs[i]) begin
         bus_wr(vecs[i].rs, vecs[i].d);
         if (vecs[i].chk)
            expect_pix($sformatf("window_vec%0d", i),
                       {9'(vecs[i].ex), 9'(vecs[i].ey), vecs[i].d});
      end

      // Random windows against the positional model
      for (int r = 0; r < 4; r++) begin
         sc = $urandom_range(0, 400);
         ec = sc + $urandom_range(0, 6);
         sp = $urandom_range(0, 300);
         ep = sp + $urandom_range(0, 4);
         n  = $urandom_range(8, 40);
         set_window(sc, ec, sp, ep);
         bus_wr(1'b0, 16'h002C);
         for (int k = 0; k < n; k++) begin
            d = 16'($urandom);
            bus_wr(1'b1, d);
            expect_pix($sformatf("rand%0d_px%0d", r, k), model_pix(sc, ec, sp, ep, k, d));
         end
      end

      // Backpressure: first held, second dropped, cursor still advances
      set_window(0, 9, 0, 9);
      bus_wr(1'b0, 16'h002C);
      pix_ready = 1'b0;
      bus_wr(1'b1, 16'h1111);
      bus_wr(1'b1, 16'h2222);
      @(negedge clk);
      check("bp_held_valid", 34'(pix_valid), 34'd1);
      check("bp_held_pixel", {pix_x, pix_y, pix_data}, {9'd0, 9'd0, 16'h1111});
      check("bp_ovf_set", 34'(pix_ovf), 34'd1);
      tick(1);
      pix_ready = 1'b1;
      expect_pix("bp_accept_held", {9'd0, 9'd0, 16'h1111});
      tick(3);
      check("bp_second_dropped", 34'(got_q.size()), 34'd0);
      bus_wr(1'b1, 16'h3333);
      expect_pix("bp_cursor_advanced", {9'd2, 9'd0, 16'h3333});
      check("bp_ovf_sticky", 34'(pix_ovf), 34'd1);

      // Read ID sequence, then a read outside RDID
      bus_wr(1'b0, 16'h00D3);
      for (int i = 0; i < 5; i++) begin
         bus_rd(d, oe_lo, oe_hi);
         check($sformatf("rdid_word%0d", i), 34'(d), 34'(id_exp[i]));
         check($sformatf("rdid_oe_low%0d", i), 34'(oe_lo), 34'd1);
         check($sformatf("rdid_oe_high%0d", i), 34'(oe_hi), 34'd0);
      end
      bus_wr(1'b0, 16'h0000);
      bus_rd(d, oe_lo, oe_hi);
      check("rd_idle_data", 34'(d), 34'd0);
      check("rd_idle_oe", 34'(oe_lo), 34'd1);

      // LCD_RST low mid-RAMWR
      set_window(0, 2, 0, 1);
      bus_wr(1'b0, 16'h002C);
      pix_ready = 1'b0;
      bus_wr(1'b1, 16'h4444);
      LCD_RST = 1'b0;
      tick(5);
      LCD_RST = 1'b1;
      tick(4);
      @(negedge clk);
      check("lcdrst_pix_valid", 34'(pix_valid), 34'd0);
      check("lcdrst_ovf_kept", 34'(pix_ovf), 34'd1);
      tick(1);
      pix_ready = 1'b1;
      got_q.delete();
      bus_wr(1'b1, 16'h5555);
      tick(3);
      check("lcdrst_idle_no_pixel", 34'(got_q.size()), 34'd0);
      bus_wr(1'b0, 16'h002C);
      for (int k = 0; k < 4; k++) begin
         d = 16'($urandom);
         bus_wr(1'b1, d);
         expect_pix($sformatf("lcdrst_default_px%0d", k), {9'(k), 9'd0, d});
      end

      // rst mid-CASET
      bus_wr(1'b0, 16'h002A);
      bus_wr(1'b1, 16'h0000);
      rst = 1'b1;
      tick(2);
      check_idle_outputs("rst_mid");
      rst = 1'b0;
      tick(2);
      got_q.delete();
      bus_wr(1'b1, 16'h0000);
      bus_wr(1'b1, 16'h6666);
      tick(3);
      check("rst_no_pixel", 34'(got_q.size()), 34'd0);
      bus_wr(1'b0, 16'h002C);
      bus_wr(1'b1, 16'h7777);
      expect_pix("rst_then_ramwr0", {9'd0, 9'd0, 16'h7777});
      bus_wr(1'b1, 16'h8888);
      expect_pix("rst_then_ramwr1", {9'd1, 9'd0, 16'h8888});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
